pri_encoder_sched: RTL

//  Parametrised, registered successor to the combinational priority encoder.

---
 rtl/pri_encoder_sched.sv | 97 +++++++++
 1 files changed

// File: rtl/pri_encoder_sched.sv
// Registered fixed-priority request scheduler.
// Request pulses set sticky pending bits. The highest-priority pending
// index is issued over a valid/ready handshake. An issued bit is cleared
// only in the cycle the consumer accepts it.
module pri_encoder_sched #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         flush,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         req_merged
);

  logic [N-1:0] pending_q, pending_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic         req_merged_q, req_merged_d;

  logic         acc;
  logic         load;
  logic [N-1:0] clr;
  logic [N-1:0] pend_nx;

  // Fixed-priority pick. An empty vector yields 0, so out_idx stays 0 when idle.
  function automatic logic [W-1:0] prio_sel(input logic [N-1:0] v);
    logic [W-1:0] sel;
    sel = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) sel = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (v[i]) sel = W'(i);
      end
    end
    return sel;
  endfunction

  // Next-state: clear on accept, set from requests (set beats clear), reload output when free.
  always_comb begin
    acc  = out_valid_q & out_ready;
    load = ~out_valid_q | out_ready;
    clr  = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = acc && (out_idx_q == W'(i));
    end
    pend_nx = (pending_q & ~clr) | req_in;

    pending_d    = pend_nx;
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    req_merged_d = |(req_in & pending_q & ~clr);

    // A stalled output stays frozen; newer requests only land in pending.
    if (load) begin
      out_valid_d = |pend_nx;
      out_idx_d   = prio_sel(pend_nx);
    end

    // Flush drops everything, including requests arriving in the same cycle.
    if (flush) begin
      pending_d    = '0;
      out_valid_d  = 1'b0;
      out_idx_d    = '0;
      req_merged_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      req_merged_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      req_merged_q <= req_merged_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign pending    = pending_q;
  assign req_merged = req_merged_q;

endmodule
